ram_scalar_arbiter: RTL and testbench
=====================================

# ram_scalar_arbiter

Round-robin arbiter that shares one single-port `ram_scalar_v2` instance among `N_REQ` requesters (scalar LSU, loader, debug port). It accepts one request per cycle over a valid/ready handshake and drives the RAM's `address/data/rden/wren` from registers. It routes each returned `q` word to the requester that issued the read, and supports a lock so one requester can hold the RAM for read-modify-write sequences.

## Interface
- `N_REQ`, 3, number of requesters (2..8)
- `AW`, 24, address width
- `DW`, 24, data width
- `RD_LAT`, 1, RAM read latency: `q` updates on the `RD_LAT`-th clock edge after the edge that samples `rden`/`address`
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous active-low reset
- `req_valid`  in  N_REQ  request pending, one bit per requester
- `req_we`  in  N_REQ  1 = write, 0 = read
- `req_lock`  in  N_REQ  keep grant after this transfer
- `req_addr`  in  N_REQ*AW  packed addresses, requester i at `[i*AW +: AW]`
- `req_wdata`  in  N_REQ*DW  packed write data, same packing
- `req_ready`  out  N_REQ  one-hot or zero; transfer when `valid & ready`
- `rsp_valid`  out  N_REQ  one-hot read-data strobe
- `rsp_data`  out  DW  read data, shared by all requesters, qualified by `rsp_valid`
- `ram_address`  out  AW  to RAM `address`
- `ram_data`  out  DW  to RAM `data`
- `ram_rden`  out  1  to RAM `rden`
- `ram_wren`  out  1  to RAM `wren`
- `ram_q`  in  DW  from RAM `q`

## Operation
- **Grant (combinational):**
  - Unlocked: highest priority goes to the first valid requester at or after `ptr`, searching upward modulo `N_REQ`.
  - `req_ready` is high only for the winner. With no valid requester, all `req_ready` are 0.
- **Pointer:** on every accepted transfer from requester i, `ptr <= (i+1) mod N_REQ`. `ptr` holds when no transfer is accepted.
- **Lock state machine:**
  - UNLOCKED → LOCKED(i) when requester i transfers with `req_lock[i]=1`.
  - In LOCKED(i), only requester i can receive ready. Ready is high whenever `req_valid[i]`; other requesters stall.
  - LOCKED(i) → UNLOCKED when i transfers with `req_lock[i]=0`.
  - A locked requester that drops `req_valid` keeps the lock.
- **Requester rule:** `req_valid/we/addr/wdata/lock` stay stable from assertion until transfer. Arbiter behaviour on a violation is undefined.
- **RAM drive (registered):** on an accepted transfer, load `ram_address`, `ram_data`, `ram_wren=we`, `ram_rden=~we`.
  - Cycle with no transfer: `ram_rden=ram_wren=0`; `ram_address`/`ram_data` keep their last value.
- **Writes:** complete with no response. Ordering is strict issue order, so a read accepted after a write to the same address returns the new data.
- **Read tag pipeline:** a shift register of depth `RD_LAT+1` carries {valid, requester id}.
  - `rsp_valid[id]` is asserted when the tag reaches the end of the pipeline.
  - `rsp_data = ram_q` (pass-through).
- **Throughput:** one transfer per cycle sustained; back-to-back reads from different requesters are allowed.

## Timing
- **Reset values:**
  - `req_ready=0` while `rst` is low.
  - `ptr=0`; state UNLOCKED.
  - `ram_address=0`, `ram_data=0`, `ram_rden=0`, `ram_wren=0`.
  - Tag pipeline cleared, `rsp_valid=0`.
- **Reset mid-operation:** in-flight reads are dropped and produce no `rsp_valid`, even if `ram_q` changes later. Any lock is released.
- **Issue timing:** transfer at edge k puts the request on the RAM during cycle k..k+1. The RAM samples it at edge k+1.
- **Read latency:** `rsp_valid[i]` is high for exactly the one cycle following edge k+1+RD_LAT-1 = k+RD_LAT. Total read latency is `RD_LAT+1` edges from acceptance.
- **Fairness:** a continuously valid, unlocked requester is granted within `N_REQ` cycles. Under a lock, the bound is extended by the lock duration.
- **Simultaneous events:** a read response for one requester and a new grant to the same requester in the same cycle are independent; both occur.
- **Width rule:** addresses and data pass unmodified; there is no address decode.

## Test plan
- **Reset:** hold `rst=0` with all `req_valid=1` → all outputs 0. Release → `req_ready=001` (ptr=0).
- **Single read:** req0 reads addr 1000 (preloaded 24'habcdef) → `ram_rden=1`, `ram_address=1000` one cycle after transfer. `rsp_valid=001` and `rsp_data=abcdef` `RD_LAT+1` edges after transfer, for one cycle only.
- **Round robin:** `req_valid=111` held, all reads → grant order 0,1,2,0,1,2. Each `rsp_valid` bit returns in the same order, one per cycle.
- **Write-then-read:** req1 writes 24'h123456 to 1001, then req2 reads 1001 on the next cycle → req2 receives 123456. No `rsp_valid` for the write.
- **Lock:**
  - req0 transfers with lock=1 (read 1002), then lock=0 (write 1002), while req1 is valid throughout → req1 ready stays 0 until req0's unlocking transfer.
  - req1 is granted the cycle after.
- **Reset mid-flight:** assert `rst=0` one cycle after a read is accepted → no `rsp_valid` ever appears for it. Outputs return to reset values immediately.

Source files
------------

// File: rtl/ram_scalar_arbiter_if.sv
// Bundle of the requester-side handshake and the RAM-side port of the
// scalar RAM arbiter. The arbiter uses the slave view. Requesters and the
// RAM use the master view.
interface ram_scalar_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 24,
  parameter int DW    = 24
) ();

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_we;
  logic [N_REQ-1:0]    req_lock;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic [AW-1:0]       ram_address;
  logic [DW-1:0]       ram_data;
  logic                ram_rden;
  logic                ram_wren;
  logic [DW-1:0]       ram_q;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, ram_q,
    output req_ready, rsp_valid, rsp_data, ram_address, ram_data, ram_rden, ram_wren
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, ram_q,
    input  req_ready, rsp_valid, rsp_data, ram_address, ram_data, ram_rden, ram_wren
  );

endinterface

// File: rtl/ram_scalar_arbiter.sv
// Round-robin arbiter that shares one single-port scalar RAM between
// N_REQ requesters. Accepted requests drive the RAM from registers. A tag
// pipeline steers each returned read word back to the requester that issued
// it. A requester can hold a lock so that it alone is served until it issues
// an unlocking transfer.
module ram_scalar_arbiter #(
  parameter int N_REQ  = 3,
  parameter int AW     = 24,
  parameter int DW     = 24,
  parameter int RD_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ram_scalar_arbiter_if.slave   bus_if
);

  localparam int IDW = $clog2(N_REQ);

  typedef logic [IDW-1:0] id_t;

  typedef enum logic {
    ST_UNLOCKED,
    ST_LOCKED
  } state_t;

  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

  state_t        state_q, state_d;
  id_t           owner_q, owner_d;
  id_t           ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          rden_q, rden_d;
  logic          wren_q, wren_d;
  tag_t          tag_q [RD_LAT+1];
  tag_t          tag_d;

  logic [N_REQ-1:0] ready;
  logic [N_REQ-1:0] rsp_valid;
  logic             found;
  logic             xfer;
  id_t              gnt_id;
  int               idx;

  // Pick the winner: the lock owner when locked, otherwise the first valid requester from ptr upward.
  always_comb begin
    ready  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (state_q == ST_LOCKED) begin
      gnt_id = owner_q;
      found  = bus_if.req_valid[owner_q];
    end else begin
      for (int off = 0; off < N_REQ; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!found && bus_if.req_valid[idx]) begin
          found  = 1'b1;
          gnt_id = id_t'(idx);
        end
      end
    end
    if (found && rst_ni) ready[gnt_id] = 1'b1;
  end

  assign xfer = |ready;

  // Next-state for lock tracking, rotation pointer and the RAM drive registers.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rden_d  = 1'b0;
    wren_d  = 1'b0;
    tag_d   = '0;
    if (xfer) begin
      ptr_d     = (gnt_id == id_t'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
      addr_d    = bus_if.req_addr[int'(gnt_id)*AW +: AW];
      data_d    = bus_if.req_wdata[int'(gnt_id)*DW +: DW];
      wren_d    = bus_if.req_we[gnt_id];
      rden_d    = ~bus_if.req_we[gnt_id];
      tag_d.vld = ~bus_if.req_we[gnt_id];
      tag_d.id  = gnt_id;
      if (bus_if.req_lock[gnt_id]) begin
        state_d = ST_LOCKED;
        owner_d = gnt_id;
      end else begin
        state_d = ST_UNLOCKED;
      end
    end
  end

  // State, pointer, RAM drive and read-tag pipeline registers; reset drops in-flight reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_UNLOCKED;
      owner_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
      for (int j = 0; j <= RD_LAT; j++) tag_q[j] <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rden_q   <= rden_d;
      wren_q   <= wren_d;
      tag_q[0] <= tag_d;
      for (int j = 1; j <= RD_LAT; j++) tag_q[j] <= tag_q[j-1];
    end
  end

  // Decode the tag leaving the pipeline into a one-hot read-data strobe.
  always_comb begin
    rsp_valid = '0;
    if (tag_q[RD_LAT].vld) rsp_valid[tag_q[RD_LAT].id] = 1'b1;
  end

  assign bus_if.req_ready   = ready;
  assign bus_if.rsp_valid   = rsp_valid;
  assign bus_if.rsp_data    = bus_if.ram_q;
  assign bus_if.ram_address = addr_q;
  assign bus_if.ram_data    = data_q;
  assign bus_if.ram_rden    = rden_q;
  assign bus_if.ram_wren    = wren_q;

endmodule

// File: tb/tb_ram_scalar_arbiter.sv
// Testbench for ram_scalar_arbiter: a table of grant vectors, hand-written
// corner-case sequences and a randomized phase, all watched continuously by a
// cycle-level reference model of the arbiter and a behavioural RAM.
module tb_ram_scalar_arbiter;

  localparam int N_REQ  = 3;
  localparam int AW     = 24;
  localparam int DW     = 24;
  localparam int RD_LAT = 1;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_scalar_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus_if ();

  ram_scalar_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bus_if)
  );

  // Behavioural single-port RAM: sampled on the rising edge, q registered.
  logic [DW-1:0] ram_mem [0:1023];
  logic [DW-1:0] ram_q_r;
  always @(posedge clk) begin
    if (bus_if.ram_wren) ram_mem[bus_if.ram_address[9:0]] = bus_if.ram_data;
    if (bus_if.ram_rden) ram_q_r <= ram_mem[bus_if.ram_address[9:0]];
  end
  assign bus_if.ram_q = ram_q_r;

  // Compare one observed value against its required value.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: pointer, lock owner, RAM drive and expected responses.
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  int            m_ptr;
  int            m_owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_rden;
  logic          m_wren;
  logic [DW-1:0] ref_mem [0:1023];
  rsp_t          rspq [$];

  function automatic int model_grant();
    int i;
    if (m_owner >= 0) return bus_if.req_valid[m_owner] ? m_owner : -1;
    for (int off = 0; off < N_REQ; off++) begin
      i = (m_ptr + off) % N_REQ;
      if (bus_if.req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Continuous checker: compare the DUT against the model every falling edge.
  initial begin
    int               g;
    logic [N_REQ-1:0] exp_rdy;
    logic [N_REQ-1:0] exp_rv;
    logic [DW-1:0]    exp_rd;
    logic [AW-1:0]    a;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ptr = 0; m_owner = -1; m_addr = '0; m_data = '0; m_rden = 1'b0; m_wren = 1'b0;
        rspq.delete();
        g = -1;
      end else begin
        g = model_grant();
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_rv = '0;
      exp_rd = '0;
      if (rspq.size() > 0 && rspq[0].due == cyc) begin
        exp_rv[rspq[0].id] = 1'b1;
        exp_rd = rspq[0].data;
        void'(rspq.pop_front());
      end
      checkOutput("model_ready", 64'(bus_if.req_ready), 64'(exp_rdy));
      checkOutput("model_rsp_valid", 64'(bus_if.rsp_valid), 64'(exp_rv));
      if (exp_rv != '0) checkOutput("model_rsp_data", 64'(bus_if.rsp_data), 64'(exp_rd));
      checkOutput("model_ram_rden", 64'(bus_if.ram_rden), 64'(m_rden));
      checkOutput("model_ram_wren", 64'(bus_if.ram_wren), 64'(m_wren));
      checkOutput("model_ram_address", 64'(bus_if.ram_address), 64'(m_addr));
      checkOutput("model_ram_data", 64'(bus_if.ram_data), 64'(m_data));
      @(posedge clk);
      cyc++;
      if (rst_n) begin
        if (g >= 0) begin
          a       = bus_if.req_addr[g*AW +: AW];
          m_addr  = a;
          m_data  = bus_if.req_wdata[g*DW +: DW];
          m_wren  = bus_if.req_we[g];
          m_rden  = ~bus_if.req_we[g];
          m_ptr   = (g + 1) % N_REQ;
          m_owner = bus_if.req_lock[g] ? g : -1;
          if (bus_if.req_we[g]) ref_mem[a[9:0]] = m_data;
          else rspq.push_back('{due: cyc + RD_LAT, id: g, data: ref_mem[a[9:0]]});
        end else begin
          m_rden = 1'b0;
          m_wren = 1'b0;
        end
      end
    end
  end

  task automatic drive(input int i, input logic v, input logic we, input logic lk,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_if.req_valid[i]          = v;
    bus_if.req_we[i]             = we;
    bus_if.req_lock[i]           = lk;
    bus_if.req_addr[i*AW +: AW]  = a;
    bus_if.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idleAll();
    bus_if.req_valid = '0;
    bus_if.req_we    = '0;
    bus_if.req_lock  = '0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N_REQ-1:0] valid;
    logic [N_REQ-1:0] we;
    logic [N_REQ-1:0] lock;
    logic [N_REQ-1:0] exp_ready;
  } vec_t;

  vec_t vecs [13];

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < N_REQ; i++)
      drive(i, v.valid[i], v.we[i], v.lock[i], AW'(16 + i), DW'(24'h00a000 + i));
  endtask

  // Stimulus sequence.
  initial begin
    logic [N_REQ-1:0] fired;

    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = DW'(24'h5a0000 ^ (i * 37));
      ref_mem[i] = DW'(24'h5a0000 ^ (i * 37));
    end
    ram_mem[1000] = 24'habcdef;
    ref_mem[1000] = 24'habcdef;

    // Grant vectors from ptr=0, unlocked; req1 writes, the others read.
    vecs[0]  = '{3'b111, 3'b010, 3'b000, 3'b001};
    vecs[1]  = '{3'b110, 3'b010, 3'b000, 3'b010};
    vecs[2]  = '{3'b101, 3'b010, 3'b000, 3'b100};
    vecs[3]  = '{3'b001, 3'b010, 3'b000, 3'b001};
    vecs[4]  = '{3'b000, 3'b010, 3'b000, 3'b000};
    vecs[5]  = '{3'b101, 3'b010, 3'b000, 3'b100};
    vecs[6]  = '{3'b011, 3'b010, 3'b010, 3'b001};
    vecs[7]  = '{3'b110, 3'b010, 3'b010, 3'b010};
    vecs[8]  = '{3'b100, 3'b010, 3'b000, 3'b000};
    vecs[9]  = '{3'b110, 3'b010, 3'b010, 3'b010};
    vecs[10] = '{3'b110, 3'b010, 3'b000, 3'b010};
    vecs[11] = '{3'b100, 3'b010, 3'b000, 3'b100};
    vecs[12] = '{3'b000, 3'b010, 3'b000, 3'b000};

    // Reset held with every requester valid: all outputs quiet.
    rst_n = 1'b0;
    idleAll();
    for (int i = 0; i < N_REQ; i++) drive(i, 1'b1, 1'b0, 1'b0, AW'(100 + i), '0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_ready", 64'(bus_if.req_ready), 64'd0);
      checkOutput("reset_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
      checkOutput("reset_ram_rden", 64'(bus_if.ram_rden), 64'd0);
      checkOutput("reset_ram_address", 64'(bus_if.ram_address), 64'd0);
    end
    nextCycle();
    rst_n = 1'b1;

    // Round robin with all three continuously valid readers.
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checkOutput("rr_grant", 64'(bus_if.req_ready), 64'(1 << (n % 3)));
      if (n >= 2) checkOutput("rr_rsp_order", 64'(bus_if.rsp_valid), 64'(1 << ((n - 2) % 3)));
      nextCycle();
    end
    idleAll();
    repeat (3) nextCycle();

    // Table-driven grant vectors.
    for (int r = 0; r < 13; r++) begin
      applyStimulus(vecs[r]);
      @(negedge clk);
      checkOutput($sformatf("table_ready_%0d", r), 64'(bus_if.req_ready), 64'(vecs[r].exp_ready));
      nextCycle();
    end
    idleAll();
    repeat (3) nextCycle();

    // Single read of the preloaded word.
    drive(0, 1'b1, 1'b0, 1'b0, AW'(1000), '0);
    @(negedge clk);
    checkOutput("single_ready", 64'(bus_if.req_ready), 64'b001);
    nextCycle();
    idleAll();
    @(negedge clk);
    checkOutput("single_ram_rden", 64'(bus_if.ram_rden), 64'd1);
    checkOutput("single_ram_address", 64'(bus_if.ram_address), 64'd1000);
    nextCycle();
    @(negedge clk);
    checkOutput("single_rsp_valid", 64'(bus_if.rsp_valid), 64'b001);
    checkOutput("single_rsp_data", 64'(bus_if.rsp_data), 64'habcdef);
    nextCycle();
    @(negedge clk);
    checkOutput("single_rsp_one_cycle", 64'(bus_if.rsp_valid), 64'd0);
    nextCycle();

    // Write by req1 followed immediately by a read of the same address by req2.
    drive(1, 1'b1, 1'b1, 1'b0, AW'(1001), 24'h123456);
    @(negedge clk);
    checkOutput("wtr_write_ready", 64'(bus_if.req_ready), 64'b010);
    nextCycle();
    idleAll();
    drive(2, 1'b1, 1'b0, 1'b0, AW'(1001), '0);
    @(negedge clk);
    checkOutput("wtr_read_ready", 64'(bus_if.req_ready), 64'b100);
    nextCycle();
    idleAll();
    @(negedge clk);
    checkOutput("wtr_no_write_rsp", 64'(bus_if.rsp_valid), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("wtr_rsp_valid", 64'(bus_if.rsp_valid), 64'b100);
    checkOutput("wtr_rsp_data", 64'(bus_if.rsp_data), 64'h123456);
    nextCycle();

    // Lock: req0 locks, pauses, then unlocks while req1 waits throughout.
    drive(1, 1'b1, 1'b0, 1'b0, AW'(5), '0);
    drive(0, 1'b1, 1'b0, 1'b1, AW'(1002), '0);
    @(negedge clk);
    checkOutput("lock_first", 64'(bus_if.req_ready), 64'b001);
    nextCycle();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("lock_hold_idle", 64'(bus_if.req_ready), 64'b000);
    nextCycle();
    drive(0, 1'b1, 1'b1, 1'b0, AW'(1002), 24'h777777);
    @(negedge clk);
    checkOutput("lock_unlocking", 64'(bus_if.req_ready), 64'b001);
    nextCycle();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("lock_release_req1", 64'(bus_if.req_ready), 64'b010);
    nextCycle();
    idleAll();
    repeat (3) nextCycle();

    // Reset one cycle after a locking read is accepted.
    drive(0, 1'b1, 1'b0, 1'b1, AW'(1000), '0);
    @(negedge clk);
    checkOutput("mid_ready", 64'(bus_if.req_ready), 64'b001);
    nextCycle();
    idleAll();
    nextCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rsp_dropped", 64'(bus_if.rsp_valid), 64'd0);
    checkOutput("mid_ram_rden", 64'(bus_if.ram_rden), 64'd0);
    checkOutput("mid_ram_address", 64'(bus_if.ram_address), 64'd0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    drive(1, 1'b1, 1'b0, 1'b0, AW'(6), '0);
    @(negedge clk);
    checkOutput("mid_lock_released", 64'(bus_if.req_ready), 64'b010);
    nextCycle();
    idleAll();
    repeat (3) begin
      @(negedge clk);
      checkOutput("mid_no_late_rsp", 64'(bus_if.rsp_valid[0]), 64'd0);
      nextCycle();
    end

    // Randomized traffic honouring the hold-until-transfer rule.
    fired = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_REQ; i++)
        if (!bus_if.req_valid[i] || fired[i])
          drive(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)), DW'($urandom));
      @(negedge clk);
      fired = bus_if.req_valid & bus_if.req_ready;
      nextCycle();
    end
    idleAll();
    repeat (6) nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
